// File: rtl/ibuf_pkg.sv
// Shared types for the instruction buffer: fetch exception codes and the
// per-entry record handed from fetch to decode.
package ibuf_pkg;

  typedef enum logic [3:0] {
    EXCP_NONE = 4'd0,
    EXCP_INT  = 4'd1,
    EXCP_ADEF = 4'd2,
    EXCP_TLBR = 4'd3,
    EXCP_PIF  = 4'd4,
    EXCP_PPI  = 4'd5,
    EXCP_SYS  = 4'd6,
    EXCP_BRK  = 4'd7,
    EXCP_INE  = 4'd8
  } excp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        have_excp;
    excp_t       excp_type;
  } ibuf_entry_t;

endpackage

// File: rtl/ibuf_ram.sv
// DEPTH-entry register file, two write ports and two combinational read ports.
// Storage is deliberately not reset; validity is tracked by the owner's count.
module ibuf_ram
  import ibuf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we0,
  input  logic [PTR_W-1:0] i_waddr0,
  input  ibuf_entry_t      i_wdata0,
  input  logic             i_we1,
  input  logic [PTR_W-1:0] i_waddr1,
  input  ibuf_entry_t      i_wdata1,
  input  logic [PTR_W-1:0] i_raddr0,
  input  logic [PTR_W-1:0] i_raddr1,
  output ibuf_entry_t      o_rdata0,
  output ibuf_entry_t      o_rdata1
);

  ibuf_entry_t r_mem [DEPTH];

  // The two write addresses are always tail and tail+1, so they never collide.
  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_waddr0] <= i_wdata0;
    if (i_we1) r_mem[i_waddr1] <= i_wdata1;
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/ibuf.sv
// Instruction buffer between fetch and a dual-issue decoder: circular FIFO
// accepting 0..2 entries and presenting up to 2 entries per cycle.
module ibuf
  import ibuf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_pc0,
  input  logic [31:0] i_inst0,
  input  logic        i_pred_taken0,
  input  logic [31:0] i_pred_target0,
  input  logic [31:0] i_pc1,
  input  logic [31:0] i_inst1,
  input  logic        i_pred_taken1,
  input  logic [31:0] i_pred_target1,
  input  logic        i_have_excp,
  input  excp_t       i_excp_type,
  output logic        i_ready,
  input  logic        flush,
  output logic        o_valid0,
  output ibuf_entry_t o_entry0,
  output logic        o_valid1,
  output ibuf_entry_t o_entry1,
  input  logic [1:0]  o_pop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [CNT_W-1:0] w_free;
  logic [CNT_W-1:0] w_size_req;
  logic [CNT_W-1:0] w_wr_n;
  logic [CNT_W-1:0] w_pop_lim;
  logic [CNT_W-1:0] w_pop_req;
  logic [CNT_W-1:0] w_pop_n;
  logic             w_we0;
  logic             w_we1;
  ibuf_entry_t      w_wdata0;
  ibuf_entry_t      w_wdata1;

  // Free space is measured before this cycle's pop: popped slots reopen next cycle.
  assign w_free     = CNT_W'(DEPTH) - r_count;
  assign w_size_req = (i_size == 2'd3) ? CNT_W'(2) : CNT_W'(i_size);
  assign w_wr_n     = (w_size_req > w_free) ? w_free : w_size_req;

  assign w_pop_lim  = (r_count > CNT_W'(2)) ? CNT_W'(2) : r_count;
  assign w_pop_req  = CNT_W'(o_pop);
  assign w_pop_n    = (w_pop_req > w_pop_lim) ? w_pop_lim : w_pop_req;

  // Margin of 4 covers one response in flight plus one landing this cycle.
  assign i_ready  = (w_free >= CNT_W'(4));
  assign o_valid0 = (r_count != '0);
  assign o_valid1 = (r_count >= CNT_W'(2));

  assign w_we0 = !flush && (w_wr_n != '0);
  assign w_we1 = !flush && (w_wr_n == CNT_W'(2));

  assign w_wdata0 = '{pc: i_pc0, inst: i_inst0, pred_taken: i_pred_taken0,
                      pred_target: i_pred_target0, have_excp: i_have_excp,
                      excp_type: i_excp_type};
  assign w_wdata1 = '{pc: i_pc1, inst: i_inst1, pred_taken: i_pred_taken1,
                      pred_target: i_pred_target1, have_excp: 1'b0,
                      excp_type: EXCP_NONE};

  ibuf_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk      (clk),
    .i_we0    (w_we0),
    .i_waddr0 (r_tail),
    .i_wdata0 (w_wdata0),
    .i_we1    (w_we1),
    .i_waddr1 (r_tail + PTR_W'(1)),
    .i_wdata1 (w_wdata1),
    .i_raddr0 (r_head),
    .i_raddr1 (r_head + PTR_W'(1)),
    .o_rdata0 (o_entry0),
    .o_rdata1 (o_entry1)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_pop_n[PTR_W-1:0];
      r_tail  <= r_tail + w_wr_n[PTR_W-1:0];
      r_count <= r_count + w_wr_n - w_pop_n;
    end
  end

  a_size_legal: assert property (@(posedge clk) disable iff (!resetn)
    i_size != 2'd3);
  a_excp_lane0: assert property (@(posedge clk) disable iff (!resetn)
    i_have_excp |-> (i_size == 2'd1));
  a_pop_legal: assert property (@(posedge clk) disable iff (!resetn || flush)
    w_pop_req <= w_pop_lim);
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn || flush)
    w_size_req <= w_free);

endmodule

// File: tb/tb_ibuf.sv
// Self-checking bench for ibuf: hand-built vector table, corner sequences and
// randomized traffic compared against a queue-based model of the buffer.
module tb_ibuf;
  import ibuf_pkg::*;

  localparam int DEPTH = 16;
  localparam int EW    = $bits(ibuf_entry_t);

  logic        clk;
  logic        resetn;
  logic [1:0]  i_size;
  logic [31:0] i_pc0, i_inst0, i_pred_target0;
  logic        i_pred_taken0;
  logic [31:0] i_pc1, i_inst1, i_pred_target1;
  logic        i_pred_taken1;
  logic        i_have_excp;
  excp_t       i_excp_type;
  logic        i_ready;
  logic        flush;
  logic        o_valid0, o_valid1;
  ibuf_entry_t o_entry0, o_entry1;
  logic [1:0]  o_pop;

  ibuf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .i_size(i_size),
    .i_pc0(i_pc0), .i_inst0(i_inst0), .i_pred_taken0(i_pred_taken0),
    .i_pred_target0(i_pred_target0),
    .i_pc1(i_pc1), .i_inst1(i_inst1), .i_pred_taken1(i_pred_taken1),
    .i_pred_target1(i_pred_target1),
    .i_have_excp(i_have_excp), .i_excp_type(i_excp_type), .i_ready(i_ready),
    .flush(flush), .o_valid0(o_valid0), .o_entry0(o_entry0),
    .o_valid1(o_valid1), .o_entry1(o_entry1), .o_pop(o_pop)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  task automatic cmp(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic ibuf_entry_t mk(input logic [31:0] pc, input logic hx, input excp_t et);
    ibuf_entry_t e;
    e.pc          = pc;
    e.inst        = pc ^ 32'h0bad_f00d;
    e.pred_taken  = pc[3];
    e.pred_target = pc + 32'h100;
    e.have_excp   = hx;
    e.excp_type   = et;
    return e;
  endfunction

  // scoreboard: the buffer is a FIFO with DEPTH slots and a 4-slot ready margin
  task automatic check_model(input string tag);
    int n;
    n = exp_q.size();
    cmp({tag, ".valid0"}, EW'(o_valid0), EW'(n >= 1));
    cmp({tag, ".valid1"}, EW'(o_valid1), EW'(n >= 2));
    cmp({tag, ".ready"},  EW'(i_ready),  EW'((DEPTH - n) >= 4));
    if (n >= 1) cmp({tag, ".entry0"}, o_entry0, exp_q[0]);
    if (n >= 2) cmp({tag, ".entry1"}, o_entry1, exp_q[1]);
  endtask

  // driver: one cycle of fetch + decode + flush activity; called at negedge
  task automatic drive(input string tag, input logic [1:0] sz, input logic [1:0] pop,
                       input logic fl, input ibuf_entry_t e0, input ibuf_entry_t e1);
    ibuf_entry_t l1;
    i_size = sz; o_pop = pop; flush = fl;
    i_pc0 = e0.pc; i_inst0 = e0.inst; i_pred_taken0 = e0.pred_taken;
    i_pred_target0 = e0.pred_target;
    i_have_excp = e0.have_excp; i_excp_type = e0.excp_type;
    i_pc1 = e1.pc; i_inst1 = e1.inst; i_pred_taken1 = e1.pred_taken;
    i_pred_target1 = e1.pred_target;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      for (int k = 0; k < int'(pop); k++) void'(exp_q.pop_front());
      if (sz >= 2'd1) exp_q.push_back(e0);
      if (sz == 2'd2) begin
        l1 = e1;
        l1.have_excp = 1'b0;
        l1.excp_type = EXCP_NONE;
        exp_q.push_back(l1);
      end
    end
    @(negedge clk);
    check_model(tag);
  endtask

  typedef struct {
    logic [1:0]  size;
    logic [1:0]  pop;
    logic        hx;
    excp_t       et;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        ev0;
    logic        ev1;
    logic [31:0] epc0;
    logic [31:0] epc1;
    logic        ehx0;
  } vec_t;

  vec_t vecs[7];
  ibuf_entry_t z;
  logic [31:0] pcn;

  initial begin
    vecs[0] = '{2'd2, 2'd0, 1'b0, EXCP_NONE, 32'h1c00_0000, 32'h1c00_0004, 1'b1, 1'b1, 32'h1c00_0000, 32'h1c00_0004, 1'b0};
    vecs[1] = '{2'd1, 2'd1, 1'b0, EXCP_NONE, 32'h1c00_0008, 32'h0,         1'b1, 1'b1, 32'h1c00_0004, 32'h1c00_0008, 1'b0};
    vecs[2] = '{2'd2, 2'd0, 1'b0, EXCP_NONE, 32'h1c00_000c, 32'h1c00_0010, 1'b1, 1'b1, 32'h1c00_0004, 32'h1c00_0008, 1'b0};
    vecs[3] = '{2'd0, 2'd2, 1'b0, EXCP_NONE, 32'h0,         32'h0,         1'b1, 1'b1, 32'h1c00_000c, 32'h1c00_0010, 1'b0};
    vecs[4] = '{2'd0, 2'd2, 1'b0, EXCP_NONE, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0};
    vecs[5] = '{2'd1, 2'd0, 1'b1, EXCP_ADEF, 32'h1c00_0002, 32'h0,         1'b1, 1'b0, 32'h1c00_0002, 32'h0,         1'b1};
    vecs[6] = '{2'd0, 2'd1, 1'b0, EXCP_NONE, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0};

    z = mk(32'h0, 1'b0, EXCP_NONE);
    resetn = 1'b0; i_size = 2'd0; o_pop = 2'd0; flush = 1'b0;
    i_pc0 = '0; i_inst0 = '0; i_pred_taken0 = 1'b0; i_pred_target0 = '0;
    i_pc1 = '0; i_inst1 = '0; i_pred_taken1 = 1'b0; i_pred_target1 = '0;
    i_have_excp = 1'b0; i_excp_type = EXCP_NONE;
    repeat (2) @(negedge clk);
    cmp("reset.valid0", EW'(o_valid0), EW'(0));
    cmp("reset.valid1", EW'(o_valid1), EW'(0));
    cmp("reset.ready",  EW'(i_ready),  EW'(1));
    resetn = 1'b1;
    @(negedge clk);

    // table-driven vectors
    for (int v = 0; v < 7; v++) begin
      drive($sformatf("vec%0d", v), vecs[v].size, vecs[v].pop, 1'b0,
            mk(vecs[v].pc0, vecs[v].hx, vecs[v].et), mk(vecs[v].pc1, 1'b0, EXCP_NONE));
      cmp($sformatf("vec%0d.tv0", v), EW'(o_valid0), EW'(vecs[v].ev0));
      cmp($sformatf("vec%0d.tv1", v), EW'(o_valid1), EW'(vecs[v].ev1));
      if (vecs[v].ev0) begin
        cmp($sformatf("vec%0d.tpc0", v), EW'(o_entry0.pc), EW'(vecs[v].epc0));
        cmp($sformatf("vec%0d.thx0", v), EW'(o_entry0.have_excp), EW'(vecs[v].ehx0));
        if (vecs[v].ehx0)
          cmp($sformatf("vec%0d.tet0", v), EW'(o_entry0.excp_type), EW'(EXCP_ADEF));
      end
      if (vecs[v].ev1) cmp($sformatf("vec%0d.tpc1", v), EW'(o_entry1.pc), EW'(vecs[v].epc1));
    end

    // fill with 2-entry writes: ready holds through count 12, drops at 14
    pcn = 32'h1c00_1000;
    for (int i = 0; i < 8; i++) begin
      drive("fill", 2'd2, 2'd0, 1'b0, mk(pcn, 1'b0, EXCP_NONE), mk(pcn + 4, 1'b0, EXCP_NONE));
      cmp($sformatf("fill%0d.ready", i), EW'(i_ready), EW'((2 * (i + 1)) <= 12));
      pcn += 8;
    end
    for (int i = 0; i < 8; i++) drive("drain", 2'd0, 2'd2, 1'b0, z, z);

    // flush wins over a same-cycle write and pop at count 6
    for (int i = 0; i < 3; i++) begin
      drive("preflush", 2'd2, 2'd0, 1'b0, mk(pcn, 1'b0, EXCP_NONE), mk(pcn + 4, 1'b0, EXCP_NONE));
      pcn += 8;
    end
    drive("flush", 2'd2, 2'd2, 1'b1, mk(pcn, 1'b0, EXCP_NONE), mk(pcn + 4, 1'b0, EXCP_NONE));
    cmp("flush.valid0", EW'(o_valid0), EW'(0));
    cmp("flush.ready",  EW'(i_ready),  EW'(1));

    // randomized traffic across many pointer wraps
    for (int c = 0; c < 400; c++) begin
      int sz, pp, fr;
      logic hx, fl;
      excp_t et;
      fr = DEPTH - exp_q.size();
      sz = $urandom_range(0, 2);
      if (sz > fr) sz = fr;
      pp = $urandom_range(0, (exp_q.size() > 2) ? 2 : exp_q.size());
      fl = ($urandom_range(0, 39) == 0);
      hx = (sz == 1) && ($urandom_range(0, 5) == 0);
      et = hx ? excp_t'(4'($urandom_range(1, 8))) : EXCP_NONE;
      drive("rand", 2'(sz), 2'(pp), fl, mk($urandom, hx, et), mk($urandom, 1'b0, EXCP_NONE));
    end

    // async reset mid-stream at count 9
    drive("prerst", 2'd0, 2'd0, 1'b1, z, z);
    for (int i = 0; i < 4; i++) begin
      drive("prerst", 2'd2, 2'd0, 1'b0, mk(pcn, 1'b0, EXCP_NONE), mk(pcn + 4, 1'b0, EXCP_NONE));
      pcn += 8;
    end
    drive("prerst", 2'd1, 2'd0, 1'b0, mk(pcn, 1'b0, EXCP_NONE), z);
    cmp("count9.valid1", EW'(o_valid1), EW'(exp_q.size() == 9));
    i_size = 2'd0; o_pop = 2'd0; flush = 1'b0; i_have_excp = 1'b0;
    #2 resetn = 1'b0;
    #1;
    exp_q.delete();
    cmp("async_rst.valid0", EW'(o_valid0), EW'(0));
    cmp("async_rst.valid1", EW'(o_valid1), EW'(0));
    cmp("async_rst.ready",  EW'(i_ready),  EW'(1));
    @(negedge clk);
    resetn = 1'b1;
    drive("postrst", 2'd0, 2'd0, 1'b0, z, z);
    drive("postrst", 2'd1, 2'd0, 1'b0, mk(32'h1c00_2000, 1'b0, EXCP_NONE), z);
    drive("postrst", 2'd0, 2'd1, 1'b0, z, z);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
